pipe_hazard_unit: RTL

//   Parametrised hazard/forwarding controller for the pipelined 16-bit CPU; sits beside the ID stage.

---
 rtl/pipe_hazard_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard/forwarding controller beside the ID stage.
// Tracks in-flight producers (EX..WB) in a shadow scoreboard and derives
// stall/bubble, IF/ID flush, freeze and per-source forward selects.
// Build option: define HAZARD_FWD_EN to enable forwarding; without it every
// producer is treated as ready only at WB and fwd_sel1/fwd_sel2 stay 0.
module pipe_hazard_unit #(
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned ALU_READY  = 1,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned FLAG_READY = 2,
    localparam int unsigned FW_W      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic              id_src1_use,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_use,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wr,
    input  logic              id_is_load,
    input  logic              id_sets_flg,
    input  logic              id_uses_flg,
    input  logic              br_taken,
    input  logic              ext_stall,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_ifid,
    output logic              freeze,
    output logic [FW_W-1:0]   fwd_sel1,
    output logic [FW_W-1:0]   fwd_sel2
);

`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Without forwarding a result is only usable once the regfile write in
    // the last stage has happened, so both producer kinds ready at STAGES.
    localparam int unsigned ALU_R = FWD_EN ? ALU_READY  : STAGES;
    localparam int unsigned LD_R  = FWD_EN ? LOAD_READY : STAGES;

    logic [STAGES:1]   vld_q, vld_d;
    logic [STAGES:1]   wr_q,  wr_d;
    logic [STAGES:1]   ld_q,  ld_d;
    logic [STAGES:1]   flg_q, flg_d;
    logic [REG_AW-1:0] dst_q [1:STAGES];
    logic [REG_AW-1:0] dst_d [1:STAGES];

    logic            hit1, hit2;
    logic            raw_haz1, raw_haz2, flag_haz;
    logic [FW_W-1:0] sel1, sel2;
    logic            stall;

    // Youngest-producer search per source, plus flag-visibility check
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        sel1     = '0;
        sel2     = '0;
        raw_haz1 = 1'b0;
        raw_haz2 = 1'b0;
        flag_haz = 1'b0;
        for (int unsigned k = 1; k <= STAGES; k++) begin
            if (!hit1 && vld_q[k] && wr_q[k] && id_src1_use &&
                id_src1 != '0 && dst_q[k] == id_src1) begin
                hit1     = 1'b1;
                sel1     = FW_W'(k);
                raw_haz1 = k < (ld_q[k] ? LD_R : ALU_R);
            end
            if (!hit2 && vld_q[k] && wr_q[k] && id_src2_use &&
                id_src2 != '0 && dst_q[k] == id_src2) begin
                hit2     = 1'b1;
                sel2     = FW_W'(k);
                raw_haz2 = k < (ld_q[k] ? LD_R : ALU_R);
            end
            if (k < FLAG_READY && vld_q[k] && flg_q[k]) begin
                flag_haz = 1'b1;
            end
        end
    end

    // Pipeline control outputs; a stall suppresses the taken-branch flush
    always_comb begin
        stall      = id_valid & (raw_haz1 | raw_haz2 | (id_uses_flg & flag_haz)) & ~ext_stall;
        stall_id   = stall;
        bubble_ex  = stall;
        flush_ifid = id_valid & br_taken & ~stall & ~ext_stall;
        freeze     = ext_stall;
        fwd_sel1   = (FWD_EN && !raw_haz1) ? sel1 : '0;
        fwd_sel2   = (FWD_EN && !raw_haz2) ? sel2 : '0;
    end

    // Scoreboard advance: shift by one stage unless frozen; stage 1 takes ID or a bubble
    always_comb begin
        vld_d = vld_q;
        wr_d  = wr_q;
        ld_d  = ld_q;
        flg_d = flg_q;
        dst_d = dst_q;
        if (!ext_stall) begin
            for (int unsigned k = 2; k <= STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                wr_d[k]  = wr_q[k-1];
                ld_d[k]  = ld_q[k-1];
                flg_d[k] = flg_q[k-1];
                dst_d[k] = dst_q[k-1];
            end
            vld_d[1] = id_valid & ~stall;
            wr_d[1]  = id_valid & ~stall & id_wr;
            ld_d[1]  = id_valid & ~stall & id_is_load;
            flg_d[1] = id_valid & ~stall & id_sets_flg;
            dst_d[1] = (id_valid & ~stall) ? id_dst : '0;
        end
    end

    // Scoreboard registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            wr_q  <= '0;
            ld_q  <= '0;
            flg_q <= '0;
            for (int unsigned k = 1; k <= STAGES; k++) begin
                dst_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            wr_q  <= wr_d;
            ld_q  <= ld_d;
            flg_q <= flg_d;
            dst_q <= dst_d;
        end
    end

endmodule
